z_store_scheduler: RTL and testbench
====================================

Name: z_store_scheduler

Overview:
- Write-side address scheduler for the Z (output) matrix; the store counterpart of the X/Y load schedulers.
- Consumes a Z_param_t job descriptor and emits one sink-streamer command (address, length) per output row-chunk.
- Tracks outstanding writes against sink completion pulses and signals job completion.
- Sits between the accelerator controller (start and params) and the data_out sink streamer.

Parameters:
ELEM_BYTES, 4, bytes per Z element; must be a power of two
MAX_OUTSTANDING, 4, maximum issued-but-uncompleted row commands; must be at least 1
CNT_W, 16, width of the pass, row and outstanding counters

Ports:
clk_i  in  1  clock
clear_i  in  1  reset; synchronous, active-high; clears all state
start_i  in  1  job start pulse; sampled only in IDLE
params_i  in  80  accelerator_package::Z_param_t {base_address, y_columns, y_row_iters, x_rows}
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse when the job completes
cmd_valid_o  out  1  sink command valid
cmd_ready_i  in  1  sink command ready
cmd_addr_o  out  32  byte address of the row-chunk
cmd_len_o  out  16  row-chunk length in elements; equals y_columns
sink_done_i  in  1  one pulse per fully written row-chunk
stall_cycles_o  out  32  cycles with cmd_valid_o=1 and cmd_ready_i=0; 0 when the feature is disabled

Behaviour:
- Reset values (clear_i=1): state IDLE; all counters 0; all outputs 0.
- clear_i has priority over every other input. When asserted mid-job, the job is abandoned with no done_o.
- States and transitions:
  - IDLE: wait for start_i.
  - LOAD: latch params. Compute ROW_STRIDE = y_columns*y_row_iters*ELEM_BYTES (32-bit, truncating) and PASS_STEP = y_columns*ELEM_BYTES.
  - ISSUE: emit commands.
  - DRAIN: wait for outstanding writes to complete.
  - DONE: one cycle, then IDLE.
- IDLE -> LOAD on start_i.
- LOAD -> DONE if any of x_rows, y_columns, y_row_iters is 0. No command is emitted.
- LOAD -> ISSUE otherwise.
- Issue order: pass p = 0..y_row_iters-1 outer, row r = 0..x_rows-1 inner (outer-product column-block order).
- cmd_addr_o = base + r*ROW_STRIDE + p*PASS_STEP, all modulo 2^32. Maintain it with running adders only; no per-command multiplier.
- Timing: start_i in cycle 0 -> LOAD in cycle 1 -> first cmd_valid_o in cycle 2.
- Handshake (valid/ready): a transfer occurs when cmd_valid_o and cmd_ready_i are both high.
  - Once asserted, cmd_valid_o and its address/length stay stable until the transfer.
  - Back-to-back transfers are allowed, one per cycle.
- cmd_valid_o is asserted in ISSUE only when outstanding < MAX_OUTSTANDING.
- Outstanding counter:
  - +1 on a transfer; -1 on sink_done_i; unchanged if both occur in the same cycle.
  - sink_done_i with outstanding=0 is ignored (assertion error in simulation).
- ISSUE -> DRAIN on the transfer of the last command (p = y_row_iters-1, r = x_rows-1).
- DRAIN -> DONE when outstanding reaches 0, including a sink_done_i that decrements to 0 in the current cycle. done_o is high in the DONE cycle.
- start_i outside IDLE is ignored.
- params_i is sampled in the LOAD cycle only; later changes have no effect on the running job.

Optional Feature:
- Macro: Z_STORE_SCHEDULER_PERF_EN.
- Defined:
  - A 32-bit saturating counter increments each cycle with cmd_valid_o=1 and cmd_ready_i=0.
  - It is cleared on clear_i and on entry to LOAD, and holds its value after DONE.
- Undefined: stall_cycles_o is tied to 0 and no counter logic is generated.

Decomposition:
- Add to accelerator_package:
  - z_sched_state_e enum (IDLE, LOAD, ISSUE, DRAIN, DONE).
  - z_sink_cmd_t struct {addr[31:0], len[15:0]}.
  - Z_SCHED_ELEM_BYTES constant.
- Z_param_t is reused unchanged.
- One natural sub-module: z_store_addr_gen, holding the pass/row counters, running address adders and a last flag. The top level holds the FSM, the outstanding counter and the perf counter.

Test Plan:
- Basic job: base=0x1000, x_rows=2, y_columns=4, y_row_iters=2, ELEM_BYTES=4, cmd_ready_i=1, sink_done_i 3 cycles after each transfer.
  -> Addresses 0x1000, 0x1020, 0x1010, 0x1030, all with len=4.
  -> done_o exactly once, after the 4th sink_done_i.
- Backpressure: MAX_OUTSTANDING=2, x_rows=4, y_columns=1, y_row_iters=1, cmd_ready_i=1, no sink_done_i.
  -> Exactly 2 transfers, then cmd_valid_o=0.
  -> One sink_done_i -> exactly one further transfer.
  -> With PERF_EN, stall_cycles_o=0 throughout (ready always high).
- Zero dimension: x_rows=0 -> busy_o for 2 cycles (LOAD, DONE), done_o pulse, cmd_valid_o never asserted.
- Stable valid: hold cmd_ready_i=0 for 5 cycles with the first command pending.
  -> cmd_valid_o and cmd_addr_o stay constant.
  -> With PERF_EN, stall_cycles_o=5.
- Simultaneous events: a transfer and sink_done_i in the same cycle leave outstanding unchanged. The final sink_done_i in DRAIN -> done_o in the next cycle.
- Clear mid-job: clear_i during ISSUE after 1 transfer -> next cycle all outputs 0 and state IDLE. A new start_i then runs a fresh job beginning again at base.

Source files
------------

// File: rtl/accelerator_package.sv
// Shared accelerator types: Z job descriptor plus the Z store scheduler's
// state enum, sink command struct and default element size.
package accelerator_package;

    typedef struct packed {
        logic [31:0] base_address;
        logic [15:0] y_columns;
        logic [15:0] y_row_iters;
        logic [15:0] x_rows;
    } Z_param_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN,
        DONE
    } z_sched_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] len;
    } z_sink_cmd_t;

    localparam int Z_SCHED_ELEM_BYTES = 4;

endpackage

// File: rtl/z_store_addr_gen.sv
// Pass/row walker for Z stores: pass-outer, row-inner, addresses kept by
// running adders so no multiplier sits on the per-command path.
module z_store_addr_gen
    import accelerator_package::*;
#(
    parameter int ELEM_BYTES = Z_SCHED_ELEM_BYTES,
    parameter int CNT_W      = 16
) (
    input  logic        clk_i,
    input  logic        clear_i,
    input  logic        load_i,
    input  Z_param_t    params_i,
    input  logic        advance_i,
    output z_sink_cmd_t cmd_o,
    output logic        last_o
);

    localparam int SHIFT = $clog2(ELEM_BYTES);

    logic [CNT_W-1:0] pass_q, row_q, pass_last_q, row_last_q;
    logic [31:0]      row_stride_q, pass_step_q, pass_base_q, addr_q;
    logic [15:0]      len_q;
    logic [31:0]      row_stride_d, pass_step_d;

    // The only multiply happens once per job, in LOAD.
    assign row_stride_d = (32'(params_i.y_columns) * 32'(params_i.y_row_iters)) << SHIFT;
    assign pass_step_d  = 32'(params_i.y_columns) << SHIFT;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            pass_q       <= '0;
            row_q        <= '0;
            pass_last_q  <= '0;
            row_last_q   <= '0;
            row_stride_q <= '0;
            pass_step_q  <= '0;
            pass_base_q  <= '0;
            addr_q       <= '0;
            len_q        <= '0;
        end else if (load_i) begin
            pass_q       <= '0;
            row_q        <= '0;
            pass_last_q  <= CNT_W'(params_i.y_row_iters - 16'd1);
            row_last_q   <= CNT_W'(params_i.x_rows - 16'd1);
            row_stride_q <= row_stride_d;
            pass_step_q  <= pass_step_d;
            pass_base_q  <= params_i.base_address;
            addr_q       <= params_i.base_address;
            len_q        <= params_i.y_columns;
        end else if (advance_i) begin
            if (row_q == row_last_q) begin
                row_q       <= '0;
                pass_q      <= pass_q + 1'b1;
                pass_base_q <= pass_base_q + pass_step_q;
                addr_q      <= pass_base_q + pass_step_q;
            end else begin
                row_q  <= row_q + 1'b1;
                addr_q <= addr_q + row_stride_q;
            end
        end
    end

    assign last_o = (row_q == row_last_q) && (pass_q == pass_last_q);
    assign cmd_o  = '{addr: addr_q, len: len_q};

endmodule

// File: rtl/z_store_scheduler.sv
// Z store scheduler: issues one sink command per output row-chunk and waits
// for sink completions. Z_STORE_SCHEDULER_PERF_EN adds a stall counter.
module z_store_scheduler
    import accelerator_package::*;
#(
    parameter int ELEM_BYTES      = Z_SCHED_ELEM_BYTES,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 16
) (
    input  logic        clk_i,
    input  logic        clear_i,
    input  logic        start_i,
    input  Z_param_t    params_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic [31:0] cmd_addr_o,
    output logic [15:0] cmd_len_o,
    input  logic        sink_done_i,
    output logic [31:0] stall_cycles_o
);

    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);

    z_sched_state_e   state_q, state_d;
    logic [CNT_W-1:0] outstanding_q;
    z_sink_cmd_t      cmd;
    logic             last, xfer, sink_ok, zero_dim;

    assign zero_dim = (params_i.x_rows == '0) || (params_i.y_columns == '0) ||
                      (params_i.y_row_iters == '0);
    assign xfer     = cmd_valid_o && cmd_ready_i;
    // Completions with nothing in flight are dropped.
    assign sink_ok  = sink_done_i && (outstanding_q != '0);

    z_store_addr_gen #(
        .ELEM_BYTES (ELEM_BYTES),
        .CNT_W      (CNT_W)
    ) u_addr_gen (
        .clk_i     (clk_i),
        .clear_i   (clear_i),
        .load_i    (state_q == LOAD),
        .params_i  (params_i),
        .advance_i (xfer),
        .cmd_o     (cmd),
        .last_o    (last)
    );

    always_ff @(posedge clk_i) begin
        if (clear_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = LOAD;
            LOAD:    state_d = zero_dim ? DONE : ISSUE;
            ISSUE:   if (xfer && last) state_d = DRAIN;
            DRAIN:   if (outstanding_q == '0 ||
                         (outstanding_q == CNT_W'(1) && sink_ok)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != IDLE);
        done_o      = (state_q == DONE);
        cmd_valid_o = (state_q == ISSUE) && (outstanding_q < MAX_OUT);
    end

    assign cmd_addr_o = cmd.addr;
    assign cmd_len_o  = cmd.len;

    always_ff @(posedge clk_i) begin
        if (clear_i)               outstanding_q <= '0;
        else if (xfer && !sink_ok) outstanding_q <= outstanding_q + 1'b1;
        else if (!xfer && sink_ok) outstanding_q <= outstanding_q - 1'b1;
    end

    assert property (@(posedge clk_i) disable iff (clear_i)
                     !(sink_done_i && outstanding_q == '0))
        else $error("sink_done_i with no outstanding writes");

`ifdef Z_STORE_SCHEDULER_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i) begin
        if (clear_i)                                   stall_q <= '0;
        else if (state_q == IDLE && start_i)           stall_q <= '0;
        else if (cmd_valid_o && !cmd_ready_i && stall_q != '1)
                                                       stall_q <= stall_q + 1'b1;
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_z_store_scheduler.sv
// Bench for z_store_scheduler: job-level reference model checked every cycle,
// plus literal expectations per scenario. Honours Z_STORE_SCHEDULER_PERF_EN.
module tb_z_store_scheduler;
    import accelerator_package::*;

    localparam int EB   = 4;
    localparam int MAXO = 2;
`ifdef Z_STORE_SCHEDULER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clear, start, cmd_ready, sink_auto, sink_man, sink_done;
    Z_param_t    params;
    logic        busy, done, cmd_valid;
    logic [31:0] cmd_addr, stall;
    logic [15:0] cmd_len;

    assign sink_done = sink_auto | sink_man;
    always #5 clk = ~clk;

    z_store_scheduler #(
        .ELEM_BYTES      (EB),
        .MAX_OUTSTANDING (MAXO),
        .CNT_W           (16)
    ) dut (
        .clk_i          (clk),
        .clear_i        (clear),
        .start_i        (start),
        .params_i       (params),
        .busy_o         (busy),
        .done_o         (done),
        .cmd_valid_o    (cmd_valid),
        .cmd_ready_i    (cmd_ready),
        .cmd_addr_o     (cmd_addr),
        .cmd_len_o      (cmd_len),
        .sink_done_i    (sink_done),
        .stall_cycles_o (stall)
    );

    int          n_cmp = 0, n_fail = 0;
    int          cyc = 0;
    int          sink_dly = 3;
    logic        auto_en = 1'b0;
    int          due_q[$];
    logic [31:0] cap_q[$];
    int          done_cnt = 0, busy_cnt = 0, valid_cnt = 0;
    int          last_sink_cyc = 0, done_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] cap_at(input int i);
        return (cap_q.size() > i) ? cap_q[i] : 32'hDEAD_BEEF;
    endfunction

    // Reference model: job phase, commands transferred, writes in flight.
    int          m_phase = 0;  // 0 idle, 1 load, 2 issue, 3 drain, 4 done
    logic [31:0] m_base = 0, m_stall = 0;
    int          m_cols = 0, m_iters = 0, m_rows = 0, m_idx = 0, m_out = 0;
    logic        m_xf, m_dec;

    function automatic logic m_valid();
        return (m_phase == 2) && (m_out < MAXO);
    endfunction

    function automatic logic [31:0] m_addr();
        int r = m_idx % m_rows;
        int p = m_idx / m_rows;
        return m_base + 32'(r) * 32'(m_cols) * 32'(m_iters) * 32'(EB)
                      + 32'(p) * 32'(m_cols) * 32'(EB);
    endfunction

    always @(posedge clk) begin
        if (clear) begin
            m_phase = 0; m_out = 0; m_idx = 0; m_stall = 0;
            m_base = 0; m_cols = 0; m_iters = 0; m_rows = 0;
        end else begin
            m_xf  = m_valid() && cmd_ready;
            m_dec = sink_done && (m_out > 0);
            if (PERF && m_valid() && !cmd_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
            m_out = m_out + int'(m_xf) - int'(m_dec);
            case (m_phase)
                0: if (start) begin m_phase = 1; m_stall = 0; end
                1: begin
                    m_base  = params.base_address;
                    m_cols  = int'(params.y_columns);
                    m_iters = int'(params.y_row_iters);
                    m_rows  = int'(params.x_rows);
                    m_idx   = 0;
                    m_phase = (m_cols == 0 || m_iters == 0 || m_rows == 0) ? 4 : 2;
                end
                2: if (m_xf) begin
                    m_idx++;
                    if (m_idx == m_rows * m_iters) m_phase = 3;
                end
                3: if (m_out == 0) m_phase = 4;
                default: m_phase = 0;
            endcase
        end
    end

    // Per-cycle comparison plus bookkeeping for the directed checks.
    logic        p_valid = 1'b0, p_ready = 1'b0, p_clear = 1'b1;
    logic [31:0] p_addr = '0;

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("done", 32'(done), 32'(m_phase == 4));
        check("cmd_valid", 32'(cmd_valid), 32'(m_valid()));
        if (m_valid()) begin
            check("cmd_addr", cmd_addr, m_addr());
            check("cmd_len", 32'(cmd_len), 32'(m_cols));
        end
        check("stall_cycles", stall, m_stall);
        if (p_valid && !p_ready && !p_clear) begin
            check("valid_hold", 32'(cmd_valid), 32'd1);
            check("addr_hold", cmd_addr, p_addr);
        end
        p_valid = cmd_valid; p_ready = cmd_ready; p_clear = clear; p_addr = cmd_addr;

        if (cmd_valid && cmd_ready) begin
            cap_q.push_back(cmd_addr);
            if (auto_en) due_q.push_back(cyc + sink_dly);
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (busy) busy_cnt++;
        if (cmd_valid) valid_cnt++;
        if (sink_done) last_sink_cyc = cyc;
    end

    // Automatic sink: one completion pulse sink_dly cycles after each transfer.
    always @(posedge clk) begin
        cyc++;
        #1;
        sink_auto = (due_q.size() > 0) && (due_q[0] == cyc);
        if (sink_auto) void'(due_q.pop_front());
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic go(input logic [31:0] base, input int cols, input int iters, input int rows);
        params = '{base_address: base, y_columns: 16'(cols),
                   y_row_iters: 16'(iters), x_rows: 16'(rows)};
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int d0;

    initial begin
        clear = 1'b1; start = 1'b0; cmd_ready = 1'b0; sink_auto = 1'b0; sink_man = 1'b0;
        params = '0;
        tick(2);
        clear = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_addr", cmd_addr, 32'd0);
        check("rst_stall", stall, 32'd0);

        // Basic job; params scrambled after LOAD must not matter.
        auto_en = 1'b1; sink_dly = 3; cmd_ready = 1'b1; cap_q.delete(); d0 = done_cnt;
        go(32'h1000, 4, 2, 2);
        tick();
        params = '{base_address: 32'hFFFF_0000, y_columns: 16'd9, y_row_iters: 16'd9, x_rows: 16'd9};
        tick(30);
        check("basic_n", 32'(cap_q.size()), 32'd4);
        check("basic_a0", cap_at(0), 32'h1000);
        check("basic_a1", cap_at(1), 32'h1020);
        check("basic_a2", cap_at(2), 32'h1010);
        check("basic_a3", cap_at(3), 32'h1030);
        check("basic_done", 32'(done_cnt - d0), 32'd1);
        check("basic_last_sink_to_done", 32'(done_cyc), 32'(last_sink_cyc + 1));
        check("basic_idle", 32'(busy), 32'd0);

        // Backpressure on outstanding limit.
        auto_en = 1'b0; cap_q.delete(); d0 = done_cnt;
        go(32'h2000, 1, 1, 4);
        tick(10);
        check("bp_xfers", 32'(cap_q.size()), 32'd2);
        check("bp_valid_low", 32'(cmd_valid), 32'd0);
        sink_man = 1'b1; tick(); sink_man = 1'b0;
        tick(4);
        check("bp_one_more", 32'(cap_q.size()), 32'd3);
        check("bp_valid_low2", 32'(cmd_valid), 32'd0);
        repeat (3) begin sink_man = 1'b1; tick(); sink_man = 1'b0; tick(); end
        tick(3);
        check("bp_all", 32'(cap_q.size()), 32'd4);
        check("bp_a3", cap_at(3), 32'h200C);
        check("bp_done", 32'(done_cnt - d0), 32'd1);
        check("bp_stall", stall, 32'd0);

        // Zero dimension.
        busy_cnt = 0; valid_cnt = 0; d0 = done_cnt;
        go(32'h2800, 4, 2, 0);
        tick(6);
        check("zero_busy", 32'(busy_cnt), 32'd2);
        check("zero_done", 32'(done_cnt - d0), 32'd1);
        check("zero_valid", 32'(valid_cnt), 32'd0);

        // Stable valid under 5 cycles of backpressure.
        auto_en = 1'b1; sink_dly = 3; cmd_ready = 1'b0; d0 = done_cnt;
        go(32'h3000, 2, 1, 1);
        tick(6);
        check("hold_valid", 32'(cmd_valid), 32'd1);
        check("hold_addr", cmd_addr, 32'h3000);
        check("hold_len", 32'(cmd_len), 32'd2);
        check("hold_stall", stall, PERF ? 32'd5 : 32'd0);
        cmd_ready = 1'b1;
        tick(12);
        check("hold_done", 32'(done_cnt - d0), 32'd1);
        check("hold_stall_after", stall, PERF ? 32'd5 : 32'd0);

        // Transfer and completion in the same cycle.
        sink_dly = 1; cap_q.delete(); d0 = done_cnt;
        go(32'h5000, 1, 1, 4);
        tick(15);
        check("sim_xfers", 32'(cap_q.size()), 32'd4);
        check("sim_done", 32'(done_cnt - d0), 32'd1);
        check("sim_done_cyc", 32'(done_cyc), 32'(last_sink_cyc + 1));

        // Clear mid-job, then a fresh job from the same base.
        auto_en = 1'b0; cap_q.delete(); d0 = done_cnt;
        go(32'h4000, 1, 1, 2);
        tick(2);
        clear = 1'b1; cmd_ready = 1'b0;
        tick();
        clear = 1'b0;
        check("clr_one_xfer", 32'(cap_q.size()), 32'd1);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_valid", 32'(cmd_valid), 32'd0);
        check("clr_addr", cmd_addr, 32'd0);
        check("clr_len", 32'(cmd_len), 32'd0);
        check("clr_stall", stall, 32'd0);
        tick(3);
        check("clr_no_done", 32'(done_cnt - d0), 32'd0);
        auto_en = 1'b1; sink_dly = 3; cmd_ready = 1'b1; cap_q.delete();
        go(32'h4000, 1, 1, 2);
        tick(20);
        check("clr_restart_a0", cap_at(0), 32'h4000);
        check("clr_restart_a1", cap_at(1), 32'h4004);
        check("clr_restart_done", 32'(done_cnt - d0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
